// File: rtl/sddr_mem_responder.sv
// Behavioural DDR3-style memory responder: command decode, per-bank open-row tracking, one burst in flight.
// Define SDDR_RESP_TIMING_CHECK_EN to enforce tRCD/tRP/tRFC with per-bank and global down-counters.
module sddr_mem_responder #(
  parameter int BANK_BITS       = 3,
  parameter int ROW_BITS        = 13,
  parameter int COL_BITS        = 10,
  parameter int DATA_BITS       = 16,
  parameter int BURST_LENGTH    = 8,
  parameter int casReadLatency  = 5,
  parameter int casWriteLatency = 5,
  parameter int MEM_ADDR_BITS   = 10,
  parameter int tRCD            = 0,
  parameter int tRP             = 0,
  parameter int tRFC            = 0
) (
  input  logic                                       ddr_clock_i,
  input  logic                                       ddr_reset_n_i,
  input  logic                                       ddr3_cke_i,
  input  logic                                       ddr3_cs_n_i,
  input  logic                                       ddr3_ras_n_i,
  input  logic                                       ddr3_cas_n_i,
  input  logic                                       ddr3_we_n_i,
  input  logic [BANK_BITS-1:0]                       ddr3_ba_i,
  input  logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0]    ddr3_addr_i,
  input  logic [1:0][DATA_BITS-1:0]                  ddr3_dq_i,
  output logic [1:0][DATA_BITS-1:0]                  ddr3_dq_o,
  output logic                                       dq_valid_o,
  output logic                                       error_o,
  output logic [2:0]                                 error_code_o
);

  localparam int NBANK  = 1 << BANK_BITS;
  localparam int NPAIR  = BURST_LENGTH / 2;
  localparam int BEAT_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int BL_LOG = $clog2(BURST_LENGTH);
  localparam int FULL_W = BANK_BITS + ROW_BITS + COL_BITS;
  localparam int DEPTH  = 1 << MEM_ADDR_BITS;
  localparam int LAT_W  = 8;
  localparam logic [COL_BITS-1:0] COL_MASK = ~COL_BITS'((1 << BL_LOG) - 1);

  localparam logic [2:0] ERR_CLOSED   = 3'd1;
  localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN = 3'd3;
  localparam logic [2:0] ERR_OVERLAP  = 3'd4;
  localparam logic [2:0] ERR_TIMING   = 3'd5;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS
  } cmd_t;

  typedef enum logic [1:0] {B_IDLE, B_PEND, B_XFER} bstate_t;

  logic [DATA_BITS-1:0]     mem [DEPTH];
  logic [NBANK-1:0]         bank_open;
  logic [ROW_BITS-1:0]      open_row [NBANK];

  cmd_t                     cmd;
  logic                     cmd_ok;
  logic                     cmd_err;
  logic [2:0]               cmd_code;
  logic [COL_BITS-1:0]      cmd_col;
  logic [FULL_W-1:0]        cmd_full;
  logic [MEM_ADDR_BITS-1:0] cmd_base;
  logic                     tim_act_bad;
  logic                     tim_rw_bad;

  bstate_t                  bstate;
  logic [LAT_W-1:0]         lat_cnt;
  logic [BEAT_W-1:0]        beat;
  logic                     b_write;
  logic                     b_ap;
  logic [BANK_BITS-1:0]     b_bank;
  logic [MEM_ADDR_BITS-1:0] b_base;

  logic                     beat_fire;
  logic                     last_pair;
  logic                     burst_close;
  logic                     mem_we;
  logic [BEAT_W-1:0]        pair;
  logic [MEM_ADDR_BITS-1:0] idx_even;
  logic [MEM_ADDR_BITS-1:0] idx_odd;

  // Only the row field and bit 10 of the address bus carry meaning here.
  logic unused_addr;
  assign unused_addr = ^ddr3_addr_i;

  always_comb begin
    cmd = CMD_NOP;
    if (ddr3_cke_i && !ddr3_cs_n_i) begin
      case ({ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  assign cmd_col  = ddr3_addr_i[COL_BITS-1:0] & COL_MASK;
  assign cmd_full = {ddr3_ba_i, open_row[ddr3_ba_i], cmd_col};
  assign cmd_base = MEM_ADDR_BITS'(cmd_full);

  always_comb begin
    cmd_ok   = 1'b0;
    cmd_err  = 1'b0;
    cmd_code = 3'd0;
    case (cmd)
      CMD_ACT: begin
        if (bank_open[ddr3_ba_i]) begin
          cmd_err  = 1'b1;
          cmd_code = ERR_ACT_OPEN;
        end else if (tim_act_bad) begin
          cmd_err  = 1'b1;
          cmd_code = ERR_TIMING;
        end else begin
          cmd_ok = 1'b1;
        end
      end
      CMD_RD, CMD_WR: begin
        if (bstate != B_IDLE) begin
          cmd_err  = 1'b1;
          cmd_code = ERR_OVERLAP;
        end else if (!bank_open[ddr3_ba_i]) begin
          cmd_err  = 1'b1;
          cmd_code = ERR_CLOSED;
        end else if (tim_rw_bad) begin
          cmd_err  = 1'b1;
          cmd_code = ERR_TIMING;
        end else begin
          cmd_ok = 1'b1;
        end
      end
      CMD_PRE: cmd_ok = 1'b1;
      CMD_REF: begin
        if (|bank_open) begin
          cmd_err  = 1'b1;
          cmd_code = ERR_REF_OPEN;
        end else begin
          cmd_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign beat_fire   = ((bstate == B_PEND) && (lat_cnt == '0)) || (bstate == B_XFER);
  assign pair        = (bstate == B_XFER) ? beat : '0;
  assign last_pair   = (pair == BEAT_W'(NPAIR - 1));
  assign burst_close = beat_fire && last_pair && b_ap;
  assign idx_even    = b_base + MEM_ADDR_BITS'({pair, 1'b0});
  assign idx_odd     = idx_even + 1'b1;
  assign mem_we      = ddr_reset_n_i && beat_fire && b_write;

`ifdef SDDR_RESP_TIMING_CHECK_EN
  logic [15:0] rcd_cnt [NBANK];
  logic [15:0] rp_cnt  [NBANK];
  logic [15:0] rfc_cnt;

  // Loading t-1 lets a command issued exactly t cycles later see zero.
  function automatic logic [15:0] tload(input int t);
    return (t > 0) ? 16'(t - 1) : 16'd0;
  endfunction

  assign tim_act_bad = (rp_cnt[ddr3_ba_i] != '0) || (rfc_cnt != '0);
  assign tim_rw_bad  = (rcd_cnt[ddr3_ba_i] != '0);

  always_ff @(posedge ddr_clock_i) begin
    if (!ddr_reset_n_i) begin
      for (int b = 0; b < NBANK; b++) begin
        rcd_cnt[b] <= '0;
        rp_cnt[b]  <= '0;
      end
      rfc_cnt <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (rcd_cnt[b] != '0) rcd_cnt[b] <= rcd_cnt[b] - 1'b1;
        if (rp_cnt[b] != '0)  rp_cnt[b]  <= rp_cnt[b] - 1'b1;
        if (cmd_ok && (cmd == CMD_PRE) &&
            (ddr3_addr_i[10] || (BANK_BITS'(b) == ddr3_ba_i)))
          rp_cnt[b] <= tload(tRP);
      end
      if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - 1'b1;
      if (cmd_ok && (cmd == CMD_ACT)) rcd_cnt[ddr3_ba_i] <= tload(tRCD);
      if (burst_close) rp_cnt[b_bank] <= tload(tRP);
      if (cmd_ok && (cmd == CMD_REF)) rfc_cnt <= tload(tRFC);
    end
  end
`else
  localparam int unused_timing_params = tRCD + tRP + tRFC;
  assign tim_act_bad = 1'b0;
  assign tim_rw_bad  = 1'b0;
`endif

  always_ff @(posedge ddr_clock_i) begin
    if (!ddr_reset_n_i) begin
      bank_open <= '0;
    end else begin
      if (cmd_ok && (cmd == CMD_ACT)) begin
        bank_open[ddr3_ba_i] <= 1'b1;
        open_row[ddr3_ba_i]  <= ddr3_addr_i[ROW_BITS-1:0];
      end
      if (cmd_ok && (cmd == CMD_PRE)) begin
        if (ddr3_addr_i[10]) bank_open <= '0;
        else                 bank_open[ddr3_ba_i] <= 1'b0;
      end
      if (burst_close) bank_open[b_bank] <= 1'b0;
    end
  end

  // Burst engine: latency countdown, then one even/odd beat pair per cycle.
  always_ff @(posedge ddr_clock_i) begin
    if (!ddr_reset_n_i) begin
      bstate     <= B_IDLE;
      ddr3_dq_o  <= '0;
      dq_valid_o <= 1'b0;
    end else begin
      ddr3_dq_o  <= '0;
      dq_valid_o <= 1'b0;
      case (bstate)
        B_IDLE: begin
          if (cmd_ok && ((cmd == CMD_RD) || (cmd == CMD_WR))) begin
            bstate  <= B_PEND;
            b_write <= (cmd == CMD_WR);
            b_ap    <= ddr3_addr_i[10];
            b_bank  <= ddr3_ba_i;
            b_base  <= cmd_base;
            lat_cnt <= (cmd == CMD_WR) ? LAT_W'(casWriteLatency - 1)
                                       : LAT_W'(casReadLatency - 1);
          end
        end
        B_PEND: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        default: ;
      endcase
      if (beat_fire) begin
        if (!b_write) begin
          ddr3_dq_o[0] <= mem[idx_even];
          ddr3_dq_o[1] <= mem[idx_odd];
          dq_valid_o   <= 1'b1;
        end
        if (last_pair) begin
          bstate <= B_IDLE;
        end else begin
          bstate <= B_XFER;
          beat   <= pair + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ddr_clock_i) begin
    if (mem_we) begin
      mem[idx_even] <= ddr3_dq_i[0];
      mem[idx_odd]  <= ddr3_dq_i[1];
    end
  end

  always_ff @(posedge ddr_clock_i) begin
    if (!ddr_reset_n_i) begin
      error_o      <= 1'b0;
      error_code_o <= 3'd0;
    end else if (cmd_err && !error_o) begin
      error_o      <= 1'b1;
      error_code_o <= cmd_code;
    end
  end

endmodule
